// File: rtl/can_pkg.sv
// Shared definitions for the CAN transmit back end: FSM encoding and bus levels.
package can_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
    } can_state_t;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam int CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_bit_timer.sv
// Bit-time counter: counts 0..brp while a bit is on the bus, flags the last
// cycle of the bit and the readback sample point.
module can_bit_timer #(
    parameter int BRP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             restart,
    input  logic [BRP_W-1:0] brp,
    input  logic [BRP_W-1:0] sample_pt,
    output logic             bit_end,
    output logic             sample_tick
);

    logic [BRP_W-1:0] cnt;

    // Counter restarts at every new bit and holds at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (active && (cnt != brp)) begin
            cnt <= cnt + BRP_W'(1);
        end
    end

    assign bit_end     = (cnt == brp);
    assign sample_tick = (cnt == sample_pt);

endmodule

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit serializer: takes unstuffed frame bits over valid/ready, inserts
// stuff bits, times each bit on tx_bus and checks the readback at the sample point.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame in progress, bus recessive, next bit accepted at once
// ST_DATA  | an upstream frame bit is on the bus
// ST_STUFF | an inserted stuff bit is on the bus, upstream is stalled
module can_tx_bit_stuffer
    import can_pkg::*;
#(
    parameter int BRP_W     = 8,
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BRP_W-1:0] brp,
    input  logic [BRP_W-1:0] sample_pt,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_stuff_en,
    input  logic             in_chk_en,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             rx_bus,
    output logic             tx_bus,
    output logic             stuff_active,
    output logic             bit_error,
    output logic             underrun,
    output logic             busy
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);

    can_state_t       state, state_n;
    logic [BRP_W-1:0] brp_q;
    logic [RUN_W-1:0] run, run_n, run_inc;
    logic             last_bit, last_bit_n;
    logic             stuff_pend, stuff_pend_n;
    logic             last_sent, last_sent_n;
    logic             chk, chk_n;
    logic             tx_n, bit_error_n, underrun_n;
    logic             active, bnd, bit_end, sample_tick, restart, xfer;

    // Bit timer runs on the bit time captured when the frame started.
    can_bit_timer #(.BRP_W(BRP_W)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .active      (active),
        .restart     (restart),
        .brp         (brp_q),
        .sample_pt   (sample_pt),
        .bit_end     (bit_end),
        .sample_tick (sample_tick)
    );

    assign active       = (state != ST_IDLE);
    assign bnd          = !active || bit_end;
    assign in_ready     = bnd && !stuff_pend && !last_sent;
    assign xfer         = in_valid && in_ready;
    assign busy         = active;
    assign stuff_active = (state == ST_STUFF);

    // Next-state decode: abort, then upstream transfer, then stuff insertion, then frame end.
    always_comb begin
        state_n      = state;
        tx_n         = tx_bus;
        chk_n        = chk;
        last_sent_n  = last_sent;
        run_n        = run;
        run_inc      = '0;
        last_bit_n   = last_bit;
        stuff_pend_n = stuff_pend;
        restart      = 1'b0;
        underrun_n   = 1'b0;
        bit_error_n  = active && sample_tick && chk && (rx_bus != tx_bus);

        if (abort) begin
            state_n      = ST_IDLE;
            tx_n         = CAN_RECESSIVE;
            chk_n        = 1'b0;
            last_sent_n  = 1'b0;
            run_n        = '0;
            last_bit_n   = 1'b0;
            stuff_pend_n = 1'b0;
            restart      = 1'b1;
            bit_error_n  = 1'b0;
        end else if (xfer) begin
            state_n     = ST_DATA;
            tx_n        = in_bit;
            chk_n       = in_chk_en;
            last_sent_n = in_last;
            restart     = 1'b1;
            if (in_stuff_en) begin
                run_inc      = ((in_bit == last_bit) && (run != '0)) ? run + RUN_W'(1) : RUN_W'(1);
                run_n        = run_inc;
                last_bit_n   = in_bit;
                stuff_pend_n = (run_inc == RUN_W'(STUFF_LEN));
            end else begin
                run_n = '0;
            end
        end else if (bnd && stuff_pend) begin
            // The stuff bit itself starts a new run of its own polarity.
            state_n      = ST_STUFF;
            tx_n         = ~last_bit;
            last_bit_n   = ~last_bit;
            run_n        = RUN_W'(1);
            stuff_pend_n = 1'b0;
            chk_n        = 1'b1;
            restart      = 1'b1;
        end else if (bnd && active) begin
            state_n     = ST_IDLE;
            tx_n        = CAN_RECESSIVE;
            chk_n       = 1'b0;
            run_n       = '0;
            last_bit_n  = 1'b0;
            last_sent_n = 1'b0;
            restart     = 1'b1;
            underrun_n  = !last_sent;
        end
    end

    // State and bus registers; bus returns to recessive asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            brp_q      <= '0;
            tx_bus     <= CAN_RECESSIVE;
            chk        <= 1'b0;
            last_sent  <= 1'b0;
            run        <= '0;
            last_bit   <= 1'b0;
            stuff_pend <= 1'b0;
            bit_error  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            if (state == ST_IDLE) begin
                brp_q <= brp;
            end
            tx_bus     <= tx_n;
            chk        <= chk_n;
            last_sent  <= last_sent_n;
            run        <= run_n;
            last_bit   <= last_bit_n;
            stuff_pend <= stuff_pend_n;
            bit_error  <= bit_error_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Directed bench for can_tx_bit_stuffer: table of per-bit-time records (upstream
// input plus expected bus bit) replayed frame by frame, plus abort and reset sequences.
module tb_can_tx_bit_stuffer;

    localparam int BRP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [BRP_W-1:0] brp, sample_pt;
    logic             abort, in_valid, in_bit, in_stuff_en, in_chk_en, in_last;
    logic             in_ready, rx_bus, tx_bus, stuff_active, bit_error, underrun, busy;
    logic             rx_force;

    assign rx_bus = rx_force ? 1'b0 : tx_bus;

    always #5 clk = ~clk;

    can_tx_bit_stuffer #(.BRP_W(BRP_W), .STUFF_LEN(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .brp          (brp),
        .sample_pt    (sample_pt),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .in_stuff_en  (in_stuff_en),
        .in_chk_en    (in_chk_en),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .rx_bus       (rx_bus),
        .tx_bus       (tx_bus),
        .stuff_active (stuff_active),
        .bit_error    (bit_error),
        .underrun     (underrun),
        .busy         (busy)
    );

    // One record per bit time on the bus; has_in=0 marks an inserted stuff bit.
    typedef struct {
        int   fid;
        logic has_in;
        logic b;
        logic se;
        logic ce;
        logic last;
        logic exp_tx;
        logic exp_stf;
    } rec_t;

    rec_t recs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic din(input int f, input logic b, input logic se, input logic ce, input logic last);
        recs.push_back(rec_t'{f, 1'b1, b, se, ce, last, b, 1'b0});
    endtask

    task automatic dstuff(input int f, input logic v);
        recs.push_back(rec_t'{f, 1'b0, v, 1'b0, 1'b0, 1'b0, v, 1'b1});
    endtask

    // Replays frame f from IDLE, checks every cycle of every bit time, then two idle cycles.
    task automatic run_frame(input int f, input int bp, input int sp, input logic frc,
                             input int exp_err, input int exp_err_cyc, input int exp_und);
        rec_t fr[$];
        int   ri = 0, cyc = -1, nerr = 0, nund = 0, err_cyc = -1, und_cyc = -1;
        int   p, total;
        logic xfer;
        foreach (recs[i]) if (recs[i].fid == f) fr.push_back(recs[i]);
        p         = bp + 1;
        total     = fr.size() * p;
        brp       = BRP_W'(bp);
        sample_pt = BRP_W'(sp);
        rx_force  = frc;
        @(negedge clk);
        for (int t = 0; t < total + 60 && cyc < total + 2; t++) begin
            if (cyc >= 0) begin
                if (cyc < total) begin
                    check($sformatf("f%0d tx c%0d", f, cyc), tx_bus, fr[cyc / p].exp_tx);
                    check($sformatf("f%0d stuff_active c%0d", f, cyc), stuff_active, fr[cyc / p].exp_stf);
                    check($sformatf("f%0d busy c%0d", f, cyc), busy, 1);
                end else begin
                    check($sformatf("f%0d idle tx c%0d", f, cyc), tx_bus, 1);
                    check($sformatf("f%0d idle busy c%0d", f, cyc), busy, 0);
                end
                if (bit_error) begin
                    nerr++;
                    if (err_cyc < 0) err_cyc = cyc;
                end
                if (underrun) begin
                    nund++;
                    if (und_cyc < 0) und_cyc = cyc;
                end
            end
            while (ri < fr.size() && !fr[ri].has_in) ri++;
            if (ri < fr.size()) begin
                in_valid    = 1'b1;
                in_bit      = fr[ri].b;
                in_stuff_en = fr[ri].se;
                in_chk_en   = fr[ri].ce;
                in_last     = fr[ri].last;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            xfer = in_valid && in_ready;
            @(posedge clk);
            if (xfer) ri++;
            if (xfer && cyc < 0) cyc = 0;
            else if (cyc >= 0) cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rx_force = 1'b0;
        check($sformatf("f%0d completed in budget", f), (cyc >= total + 2), 1);
        check($sformatf("f%0d bit_error count", f), nerr, exp_err);
        if (exp_err > 0) check($sformatf("f%0d bit_error cycle", f), err_cyc, exp_err_cyc);
        check($sformatf("f%0d underrun count", f), nund, exp_und);
        if (exp_und > 0) check($sformatf("f%0d underrun cycle", f), und_cyc, total);
    endtask

    // Offers one bit starting at a negedge, waits for in_ready, returns at the next negedge.
    task automatic send_bit(input logic b, input logic se, input logic ce, input logic last);
        int n = 0;
        in_valid    = 1'b1;
        in_bit      = b;
        in_stuff_en = se;
        in_chk_en   = ce;
        in_last     = last;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_bit ready timeout", n, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // f1: seven dominant bits -> stuff after the fifth
        for (int i = 0; i < 5; i++) din(1, 1'b0, 1'b1, 1'b1, 1'b0);
        dstuff(1, 1'b1);
        din(1, 1'b0, 1'b1, 1'b1, 1'b0);
        din(1, 1'b0, 1'b1, 1'b1, 1'b1);
        // f2: alternating pattern, never stuffed
        for (int i = 0; i < 10; i++) din(2, 1'(i % 2), 1'b1, 1'b1, (i == 9));
        // f3: pending stuff carried into an unstuffed bit
        for (int i = 0; i < 5; i++) din(3, 1'b1, 1'b1, 1'b1, 1'b0);
        dstuff(3, 1'b0);
        din(3, 1'b1, 1'b0, 1'b1, 1'b1);
        // f4/f5: readback stuck dominant, recessive bit checked / unchecked
        din(4, 1'b0, 1'b1, 1'b1, 1'b0);
        din(4, 1'b1, 1'b1, 1'b1, 1'b0);
        din(4, 1'b0, 1'b1, 1'b1, 1'b1);
        din(5, 1'b0, 1'b1, 1'b1, 1'b0);
        din(5, 1'b1, 1'b1, 1'b0, 1'b0);
        din(5, 1'b0, 1'b1, 1'b1, 1'b1);
        // f6: upstream runs dry without in_last
        din(6, 1'b0, 1'b1, 1'b1, 1'b0);
        din(6, 1'b1, 1'b1, 1'b1, 1'b0);
        din(6, 1'b0, 1'b1, 1'b1, 1'b0);
        // f7: shortest legal bit time
        din(7, 1'b1, 1'b1, 1'b1, 1'b0);
        din(7, 1'b0, 1'b1, 1'b1, 1'b0);
        din(7, 1'b1, 1'b1, 1'b1, 1'b1);
        // f8: after abort, four recessive bits must not trigger a stuff bit
        for (int i = 0; i < 4; i++) din(8, 1'b1, 1'b1, 1'b1, (i == 3));

        rst         = 1'b1;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        in_stuff_en = 1'b0;
        in_chk_en   = 1'b0;
        in_last     = 1'b0;
        rx_force    = 1'b0;
        brp         = BRP_W'(3);
        sample_pt   = BRP_W'(2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset tx_bus", tx_bus, 1);
        check("reset in_ready", in_ready, 1);
        check("reset stuff_active", stuff_active, 0);
        check("reset bit_error", bit_error, 0);
        check("reset underrun", underrun, 0);
        check("reset busy", busy, 0);

        run_frame(1, 3, 2, 1'b0, 0, -1, 0);
        run_frame(2, 3, 2, 1'b0, 0, -1, 0);
        run_frame(3, 3, 2, 1'b0, 0, -1, 0);
        run_frame(4, 3, 2, 1'b1, 1, 7, 0);
        run_frame(5, 3, 2, 1'b1, 0, -1, 0);
        run_frame(6, 3, 2, 1'b0, 0, -1, 1);
        run_frame(7, 1, 1, 1'b0, 0, -1, 0);

        // Abort in the middle of a stuff bit, with a transfer offered in the same cycle.
        brp       = BRP_W'(3);
        sample_pt = BRP_W'(2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (!stuff_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("abort: stuff bit reached", stuff_active, 1);
        check("abort: in_ready low in stuff", in_ready, 0);
        check("abort: tx stuff value", tx_bus, 1);
        abort       = 1'b1;
        in_valid    = 1'b1;
        in_bit      = 1'b0;
        in_stuff_en = 1'b1;
        in_chk_en   = 1'b1;
        in_last     = 1'b0;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort: busy cleared", busy, 0);
        check("abort: tx recessive", tx_bus, 1);
        check("abort: stuff_active cleared", stuff_active, 0);
        check("abort: in_ready restored", in_ready, 1);
        run_frame(8, 3, 2, 1'b0, 0, -1, 0);

        // Asynchronous reset in the middle of a dominant bit.
        @(negedge clk);
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        check("mid-frame busy before rst", busy, 1);
        check("mid-frame tx before rst", tx_bus, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst tx_bus", tx_bus, 1);
        check("async rst in_ready", in_ready, 1);
        check("async rst stuff_active", stuff_active, 0);
        check("async rst bit_error", bit_error, 0);
        check("async rst underrun", underrun, 0);
        check("async rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post rst busy", busy, 0);
        check("post rst underrun", underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
